// File: rtl/ram_fifo_pkg.sv
// Shared constants for the RAM-backed FIFO controller: geometry and the
// encoding used by the arbiter to remember which operation last used the RAM.
package ram_fifo_pkg;

    localparam int AW    = 3;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    // Op encoding doubles as the bit index into the arbiter req/gnt vectors.
    localparam logic OP_WR = 1'b0;
    localparam logic OP_RD = 1'b1;

endpackage

// File: rtl/ram_8bit.sv
// Single-port RAM, 2**AW x DW, synchronous write and registered read.
// data_out reflects the address presented on the previous rising edge.
module ram_8bit #(
    parameter int AW = 3,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] address,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[address] <= data_in;
        end
        data_out <= mem[address];
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: on contention it grants the requester
// that did not win last time. The last-grant register only moves on a grant.
module rr_arb2
    import ram_fifo_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_op;

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt[OP_WR] = (last_op == OP_RD);
            gnt[OP_RD] = (last_op == OP_WR);
        end else begin
            gnt = req;
        end
    end

    // Reset to READ so that the first contended cycle goes to the writer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_op <= OP_RD;
        end else if (gnt[OP_WR]) begin
            last_op <= OP_WR;
        end else if (gnt[OP_RD]) begin
            last_op <= OP_RD;
        end
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a single-port RAM: owns the pointers and
// occupancy, multiplexes the one RAM port between enqueue and dequeue.
module ram_fifo_ctrl
    import ram_fifo_pkg::OP_WR, ram_fifo_pkg::OP_RD;
#(
    parameter int AW = ram_fifo_pkg::AW,
    parameter int DW = ram_fifo_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    input  logic          rd_req,
    output logic          rd_grant,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic [AW-1:0] ram_address,
    output logic          ram_we,
    output logic [DW-1:0] ram_data_in,
    input  logic [DW-1:0] ram_data_out
);

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(2**AW);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [1:0]    req;
    logic [1:0]    gnt;
    logic          wr_fire;
    logic          rd_fire;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    always_comb begin
        req        = 2'b00;
        req[OP_WR] = wr_valid & ~full;
        req[OP_RD] = rd_req & ~empty;
    end

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    assign wr_fire = gnt[OP_WR];
    assign rd_fire = gnt[OP_RD];

    // RAM port mux: the read pointer is parked on the address when idle.
    assign wr_ready    = wr_fire;
    assign rd_grant    = rd_fire;
    assign ram_we      = wr_fire;
    assign ram_address = wr_fire ? wptr : rptr;
    assign ram_data_in = wr_fire ? wr_data : '0;

    // The RAM registers its read data, so rd_data is a straight pass-through
    // qualified by rd_valid one cycle after the grant.
    assign rd_data = ram_data_out;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            if (wr_fire) begin
                wptr  <= wptr + PTR_ONE;
                count <= count + CNT_ONE;
            end else if (rd_fire) begin
                rptr  <= rptr + PTR_ONE;
                count <= count - CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl paired with ram_8bit: linear sequence of
// steps, each comparison an immediate assertion against hand-derived values.
module tb_ram_fifo_ctrl;

    localparam int AW = 3;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          rd_req;
    logic          rd_grant;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic [AW-1:0] ram_address;
    logic          ram_we;
    logic [DW-1:0] ram_data_in;
    logic [DW-1:0] ram_data_out;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_fifo_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .rd_req       (rd_req),
        .rd_grant     (rd_grant),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .ram_address  (ram_address),
        .ram_we       (ram_we),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out)
    );

    ram_8bit #(.AW(AW), .DW(DW)) u_ram (
        .clk      (clk),
        .we       (ram_we),
        .address  (ram_address),
        .data_in  (ram_data_in),
        .data_out (ram_data_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled at the negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v3 [3];
        logic [7:0] exp_q [4];
        v3[0] = 8'hAA; v3[1] = 8'hCC; v3[2] = 8'hF0;
        exp_q[0] = 8'h54; exp_q[1] = 8'h60; exp_q[2] = 8'h61; exp_q[3] = 8'h62;

        rst = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_ram_we", 32'(ram_we), 0);

        // Three back-to-back writes
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_data = v3[i];
            #1;
            chk("w3_ready", 32'(wr_ready), 1);
            chk("w3_addr", 32'(ram_address), 32'(i));
            chk("w3_we", 32'(ram_we), 1);
            tick();
        end
        wr_valid = 1'b0;
        #1;
        chk("w3_count", 32'(count), 3);

        // Three reads
        for (int i = 0; i < 3; i++) begin
            rd_req = 1'b1;
            #1;
            chk("r3_grant", 32'(rd_grant), 1);
            chk("r3_addr", 32'(ram_address), 32'(i));
            tick();
            chk("r3_valid", 32'(rd_valid), 1);
            chk("r3_data", 32'(rd_data), 32'(v3[i]));
        end
        rd_req = 1'b0;
        #1;
        chk("r3_empty", 32'(empty), 1);
        chk("r3_count", 32'(count), 0);
        tick();
        chk("r3_valid_drop", 32'(rd_valid), 0);

        // Fill 8 words starting at wptr=3, wrapping through address 0
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1; wr_data = 8'(8'h10 + i);
            #1;
            chk("fill_ready", 32'(wr_ready), 1);
            chk("fill_addr", 32'(ram_address), 32'((3 + i) % 8));
            tick();
        end
        wr_data = 8'h99;
        #1;
        chk("full_flag", 32'(full), 1);
        chk("full_count", 32'(count), 8);
        chk("full_wr_ready", 32'(wr_ready), 0);
        chk("full_ram_we", 32'(ram_we), 0);
        tick();
        wr_valid = 1'b0;
        chk("full_count_hold", 32'(count), 8);

        // Drain 8 from rptr=3, wrapping
        for (int i = 0; i < 8; i++) begin
            rd_req = 1'b1;
            #1;
            chk("drain_grant", 32'(rd_grant), 1);
            chk("drain_addr", 32'(ram_address), 32'((3 + i) % 8));
            tick();
            chk("drain_data", 32'(rd_data), 32'(8'h10 + i));
        end
        rd_req = 1'b0;
        #1;
        chk("drain_empty", 32'(empty), 1);

        // Set up count=4 with last op = read
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1; wr_data = 8'(8'h50 + i);
            tick();
        end
        wr_valid = 1'b0; rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("pre_alt_data", 32'(rd_data), 32'h50);
        chk("pre_alt_count", 32'(count), 4);

        // Contention: expect W,R,W,R,W,R
        for (int k = 0; k < 6; k++) begin
            wr_valid = 1'b1; wr_data = 8'(8'h60 + k / 2); rd_req = 1'b1;
            #1;
            chk("alt_count", 32'(count), 32'((k % 2 == 0) ? 4 : 5));
            chk("alt_wr_ready", 32'(wr_ready), 32'(k % 2 == 0));
            chk("alt_rd_grant", 32'(rd_grant), 32'(k % 2 == 1));
            if (k == 2 || k == 4) begin
                chk("alt_rd_valid", 32'(rd_valid), 1);
                chk("alt_rd_data", 32'(rd_data), 32'(8'h51 + (k / 2 - 1)));
            end
            tick();
        end
        wr_valid = 1'b0; rd_req = 1'b0;
        #1;
        chk("alt_last_valid", 32'(rd_valid), 1);
        chk("alt_last_data", 32'(rd_data), 32'h53);
        chk("alt_end_count", 32'(count), 4);

        for (int i = 0; i < 4; i++) begin
            rd_req = 1'b1;
            tick();
            chk("alt_drain_data", 32'(rd_data), 32'(exp_q[i]));
        end
        rd_req = 1'b0;
        #1;
        chk("alt_drain_empty", 32'(empty), 1);

        // Read request on empty FIFO
        rd_req = 1'b1;
        #1;
        chk("empty_grant", 32'(rd_grant), 0);
        tick();
        chk("empty_valid0", 32'(rd_valid), 0);
        tick();
        chk("empty_valid1", 32'(rd_valid), 0);
        rd_req = 1'b0;

        // Write then immediate read of the same slot
        wr_valid = 1'b1; wr_data = 8'h5A;
        tick();
        wr_valid = 1'b0; rd_req = 1'b1;
        #1;
        chk("wr_rd_grant", 32'(rd_grant), 1);
        tick();
        rd_req = 1'b0;
        chk("wr_rd_valid", 32'(rd_valid), 1);
        chk("wr_rd_data", 32'(rd_data), 32'h5A);

        // Reset on the grant edge squashes the pending rd_valid
        wr_valid = 1'b1; wr_data = 8'h77;
        tick();
        wr_data = 8'h78;
        tick();
        wr_valid = 1'b0; rd_req = 1'b1;
        #1;
        chk("mid_rst_grant", 32'(rd_grant), 1);
        rst = 1'b0;
        tick();
        rst = 1'b1; rd_req = 1'b0;
        chk("mid_rst_valid", 32'(rd_valid), 0);
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_empty", 32'(empty), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- FIFO controller sitting directly upstream of the 8-entry x 8-bit single-port RAM (ram_8bit).
- Accepts a write stream and read requests from neighbouring logic.
- Drives the RAM's address, we and data_in ports and returns the RAM's data_out as FIFO read data.
- Arbitrates the single RAM port, with at most one RAM access per cycle.

Parameters:
- AW, 3, address width; FIFO depth is 2**AW (8).
- DW, 8, data width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-low (0 = reset, sampled on rising clk).
- wr_valid  input  1  producer has a word on wr_data.
- wr_data  input  DW  word to enqueue.
- wr_ready  output  1  write accepted this cycle when high together with wr_valid.
- rd_req  input  1  consumer requests one word.
- rd_grant  output  1  read issued to RAM this cycle.
- rd_valid  output  1  rd_data is valid (one cycle after rd_grant).
- rd_data  output  DW  dequeued word.
- full  output  1  count == 2**AW.
- empty  output  1  count == 0.
- count  output  AW+1  current occupancy.
- ram_address  output  AW  to RAM address.
- ram_we  output  1  to RAM we.
- ram_data_in  output  DW  to RAM data_in.
- ram_data_out  input  DW  from RAM data_out.

Behaviour:
- RAM contract: write on the rising clk when we = 1; read data is registered, so ram_data_out reflects the address presented in the previous cycle.
- Reset (rst = 0 at an edge):
  - wptr = 0, rptr = 0, count = 0, last_op = READ (so write wins first), rd_valid = 0.
  - Outputs: empty = 1, full = 0.
  - RAM contents are not cleared.
- Eligibility:
  - wr_elig = wr_valid & !full.
  - rd_elig = rd_req & !empty.
- Arbitration (combinational, 2-way round-robin on last_op):
  - Only wr_elig: write.
  - Only rd_elig: read.
  - Both: the op opposite to last_op.
  - last_op updates only when an op fires.
- Write fire:
  - wr_ready = 1, ram_we = 1, ram_address = wptr, ram_data_in = wr_data.
  - wptr increments, wrapping 7 -> 0.
- Read fire:
  - rd_grant = 1, ram_we = 0, ram_address = rptr.
  - rptr increments with wrap.
  - rd_valid = 1 on the next cycle, with rd_data = ram_data_out (pass-through).
- Idle cycle (no op fires): ram_we = 0, ram_address = rptr, ram_data_in = 0.
- wr_ready is 0 whenever a write does not fire, including when it loses arbitration. The producer must hold wr_data until accepted.
- rd_req is a level signal; one word is granted per rd_grant.
- count update:
  - +1 on a write fire, -1 on a read fire.
  - Never both in one cycle, so no simultaneous update case exists.
- full and empty are decoded from registered count; they update the cycle after the fire.
- Full: writes blocked and wr_ready = 0; reads proceed.
- Empty: rd_grant = 0 and rd_valid stays 0; writes proceed.
- A write followed immediately by a read of the same slot returns the new data, because the write commits at edge N and the read is addressed at N+1.
- Reset mid-operation: a pending rd_valid is squashed to 0 on the reset edge, and any in-flight write data is lost.
- rd_valid is a single-cycle pulse per grant. The consumer must capture it; there is no backpressure on the read-data side.

Decomposition:
- Package ram_fifo_pkg: AW = 3, DW = 8, DEPTH = 8, op encoding localparams OP_WR = 1'b0 and OP_RD = 1'b1.
- Sub-module rr_arb2: 2-request round-robin arbiter with req[1:0], gnt[1:0], a last-grant register, clk/rst.
- Pointers, count and RAM muxing stay in ram_fifo_ctrl.
- Bench instantiates ram_fifo_ctrl and ram_8bit together.

Test Plan:
- Reset, then idle 2 cycles -> count = 0, empty = 1, full = 0, rd_valid = 0, ram_we = 0.
- Write 8'hAA, 8'hCC, 8'hF0 back-to-back with rd_req = 0 -> wr_ready = 1 for 3 cycles, ram_address = 0, 1, 2, count = 3.
- Then 3 reads -> rd_grant on 3 cycles, rd_valid the next cycle each, rd_data = AA, CC, F0, then empty = 1.
- Fill 8 words 8'h10..8'h17 -> full = 1, count = 8.
- With full = 1, present wr_valid with 8'h99 -> wr_ready = 0 and ram_we stays 0.
- Drain all 8 -> data 10..17 in order, with a pointer wrap check.
- Hold wr_valid = 1 and rd_req = 1 with count = 4 for 6 cycles -> ops alternate W,R,W,R,W,R (write first after reset) and count stays at 4 or 5.
- Empty FIFO, rd_req = 1 only -> rd_grant = 0 and no rd_valid.
- Write 8'h5A then read on the very next cycle -> rd_data = 5A.
- Issue a read grant, assert rst = 0 on the following edge -> rd_valid = 0 after the edge, count = 0, empty = 1.
